// File: rtl/bounce_seq_checker_pkg.sv
// Shared types for the bounce-counter receiver: tracking states and direction encoding.
package bounce_pkg;
  typedef enum logic [1:0] {ST_EMPTY, ST_ACQ, ST_UP, ST_DOWN} state_t;
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;
endpackage

// File: rtl/bounce_seq_checker_if.sv
// Sample stream in, recovered sequence status out.
interface bounce_seq_checker_if #(parameter int WIDTH = 4, parameter int ERR_W = 8);
  logic             s_valid;
  logic [WIDTH-1:0] s;
  logic             clr_err;
  logic             dir;
  logic             locked;
  logic             turn;
  logic             period_done;
  logic             step_err;
  logic [ERR_W-1:0] err_cnt;

  modport master (output s_valid, s, clr_err,
                  input  dir, locked, turn, period_done, step_err, err_cnt);
  modport slave  (input  s_valid, s, clr_err,
                  output dir, locked, turn, period_done, step_err, err_cnt);
endinterface

// File: rtl/bounce_seq_checker_sat_counter.sv
// Saturating up-counter; a clear in the same cycle as an increment leaves it at 1.
module sat_counter #(parameter int W = 8) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);
  localparam logic [W-1:0] Q_MAX = {W{1'b1}};
  localparam logic [W-1:0] Q_ONE = W'(1);

  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr)                     q_d = inc ? Q_ONE : '0;
    else if (inc && q_q != Q_MAX) q_d = q_q + Q_ONE;
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) q_q <= '0;
    else      q_q <= q_d;

  assign q = q_q;
endmodule

// File: rtl/bounce_seq_checker.sv
// Receiver for the up/down bounce counter: classifies each sampled step, tracks
// direction and lock, and flags turn points, full periods and illegal steps.
module bounce_seq_checker
  import bounce_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int ERR_W  = 8,
  parameter int LOCK_N = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  bounce_seq_checker_if.slave  bus
);
  localparam int               RUN_W    = $clog2(LOCK_N + 1);
  localparam logic [WIDTH-1:0] MAX      = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(LOCK_N);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(LOCK_N - 1);
  localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             dir_q, dir_d, locked_q, locked_d;
  logic             turn_q, turn_d, period_done_q, period_done_d, step_err_q, step_err_d;
  logic             up_ok, dn_ok, legal, illegal;
  logic [ERR_W-1:0] err_cnt;

  // Wrap steps are excluded by guarding the endpoints before the +/-1 compare.
  always_comb begin
    up_ok = (prev_q != MAX) && (bus.s == prev_q + ONE);
    dn_ok = (prev_q != '0)  && (bus.s == prev_q - ONE);
    case (state_q)
      ST_ACQ:  legal = up_ok | dn_ok;
      ST_UP:   legal = up_ok;
      ST_DOWN: legal = dn_ok;
      default: legal = 1'b0;
    endcase
    illegal = bus.s_valid && (state_q != ST_EMPTY) && !legal;
  end

  always_comb begin
    state_d       = state_q;
    prev_d        = prev_q;
    run_d         = run_q;
    dir_d         = dir_q;
    locked_d      = locked_q;
    turn_d        = 1'b0;
    period_done_d = 1'b0;
    step_err_d    = 1'b0;
    if (bus.s_valid) begin
      prev_d = bus.s;
      if (state_q == ST_EMPTY) begin
        state_d = ST_ACQ;
      end else if (legal) begin
        run_d    = (run_q >= RUN_LAST) ? RUN_MAX : run_q + RUN_ONE;
        locked_d = (run_q >= RUN_LAST);
        if (bus.s == MAX) begin
          state_d = ST_DOWN;
          dir_d   = DIR_DOWN;
          turn_d  = 1'b1;
        end else if (bus.s == '0) begin
          state_d       = ST_UP;
          dir_d         = DIR_UP;
          turn_d        = 1'b1;
          period_done_d = locked_q && (state_q == ST_DOWN);
        end else if (up_ok) begin
          state_d = ST_UP;
          dir_d   = DIR_UP;
        end else begin
          state_d = ST_DOWN;
          dir_d   = DIR_DOWN;
        end
      end else begin
        // Resync: keep dir, drop lock, wait for a fresh legal step.
        step_err_d = 1'b1;
        locked_d   = 1'b0;
        run_d      = '0;
        state_d    = ST_ACQ;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_EMPTY;
      prev_q        <= '0;
      run_q         <= '0;
      dir_q         <= DIR_UP;
      locked_q      <= 1'b0;
      turn_q        <= 1'b0;
      period_done_q <= 1'b0;
      step_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      prev_q        <= prev_d;
      run_q         <= run_d;
      dir_q         <= dir_d;
      locked_q      <= locked_d;
      turn_q        <= turn_d;
      period_done_q <= period_done_d;
      step_err_q    <= step_err_d;
    end
  end

  sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .clr (bus.clr_err),
    .inc (illegal),
    .q   (err_cnt)
  );

  assign bus.dir         = dir_q;
  assign bus.locked      = locked_q;
  assign bus.turn        = turn_q;
  assign bus.period_done = period_done_q;
  assign bus.step_err    = step_err_q;
  assign bus.err_cnt     = err_cnt;
endmodule

// File: tb/tb_bounce_seq_checker.sv
// Bench for bounce_seq_checker: a behavioural model feeds a scoreboard checked every
// cycle, plus per-scenario checks against hand-derived values. Two DUTs share stimulus
// (ERR_W=8 and ERR_W=2) so saturation is seen on the narrow counter.
module tb_bounce_seq_checker;
  localparam int MAXV = 15;
  localparam int LOCK = 2;
  localparam int S_EMPTY = 0, S_ACQ = 1, S_UP = 2, S_DOWN = 3;

  typedef struct packed {
    logic       dir;
    logic       locked;
    logic       turn;
    logic       pd;
    logic       serr;
    logic [7:0] e8;
    logic [1:0] e2;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bounce_seq_checker_if #(.WIDTH(4), .ERR_W(8)) bus8 ();
  bounce_seq_checker_if #(.WIDTH(4), .ERR_W(2)) bus2 ();

  bounce_seq_checker #(.WIDTH(4), .ERR_W(8), .LOCK_N(LOCK)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  bounce_seq_checker #(.WIDTH(4), .ERR_W(2), .LOCK_N(LOCK)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  int   nchecks = 0;
  int   nerr    = 0;
  obs_t sb[$];

  int m_state, m_prev, m_dir, m_locked, m_run, m_e8, m_e2;

  task automatic model_reset();
    m_state = S_EMPTY; m_prev = 0; m_dir = 0; m_locked = 0; m_run = 0; m_e8 = 0; m_e2 = 0;
  endtask

  task automatic model_step(input bit v, input int sv, input bit clr, output obs_t e);
    bit up, dn, ok, was_down, was_locked;
    e = '0;
    if (v) begin
      if (m_state == S_EMPTY) m_state = S_ACQ;
      else begin
        up = (sv == m_prev + 1);
        dn = (sv == m_prev - 1);
        ok = (m_state == S_ACQ) ? (up || dn) : (m_state == S_UP) ? up : dn;
        if (ok) begin
          was_down = (m_state == S_DOWN);
          was_locked = (m_locked != 0);
          m_run = (m_run + 1 > LOCK) ? LOCK : m_run + 1;
          m_locked = (m_run >= LOCK);
          if (sv == MAXV) begin m_state = S_DOWN; m_dir = 1; e.turn = 1'b1; end
          else if (sv == 0) begin
            m_state = S_UP; m_dir = 0; e.turn = 1'b1;
            e.pd = was_locked && was_down;
          end
          else if (up) begin m_state = S_UP; m_dir = 0; end
          else begin m_state = S_DOWN; m_dir = 1; end
        end else begin
          e.serr = 1'b1; m_locked = 0; m_run = 0; m_state = S_ACQ;
        end
      end
      m_prev = sv;
    end
    if (clr) begin
      m_e8 = e.serr ? 1 : 0;
      m_e2 = e.serr ? 1 : 0;
    end else if (e.serr) begin
      if (m_e8 < 255) m_e8++;
      if (m_e2 < 3) m_e2++;
    end
    e.dir = m_dir[0]; e.locked = m_locked[0];
    e.e8 = m_e8[7:0]; e.e2 = m_e2[1:0];
  endtask

  // Called at a falling edge; returns at the next falling edge with outputs updated.
  task automatic sample(input bit v, input int sv, input bit clr);
    obs_t e;
    bus8.s_valid = v; bus8.s = sv[3:0]; bus8.clr_err = clr;
    bus2.s_valid = v; bus2.s = sv[3:0]; bus2.clr_err = clr;
    model_step(v, sv, clr, e);
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus8.s_valid = 1'b0; bus8.s = '0; bus8.clr_err = 1'b0;
    bus2.s_valid = 1'b0; bus2.s = '0; bus2.clr_err = 1'b0;
    sb.delete();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  always @(posedge clk) begin
    obs_t e, g;
    #1;
    if (rst && sb.size() > 0) begin
      e = sb.pop_front();
      g = '{bus8.dir, bus8.locked, bus8.turn, bus8.period_done, bus8.step_err,
            bus8.err_cnt, bus2.err_cnt};
      nchecks++;
      if (g !== e) begin
        nerr++;
        $display("FAIL scoreboard t=%0t got=%h exp=%h (dir,lock,turn,pd,serr,e8,e2)", $time, g, e);
      end
    end
  end

  task automatic test_reset();
    do_reset();
    nchecks++;
    if ({bus8.dir, bus8.locked, bus8.turn, bus8.period_done, bus8.step_err} !== 5'b0) begin
      nerr++;
      $display("FAIL reset_flags got=%b exp=00000", {bus8.dir, bus8.locked, bus8.turn, bus8.period_done, bus8.step_err});
    end
    nchecks++;
    if (bus8.err_cnt !== 8'd0 || bus2.err_cnt !== 2'd0) begin
      nerr++;
      $display("FAIL reset_err_cnt got=%0d/%0d exp=0/0", bus8.err_cnt, bus2.err_cnt);
    end
  endtask

  task automatic test_period();
    int v, turns, pds;
    do_reset();
    turns = 0; pds = 0;
    for (int i = 0; i < 32; i++) begin
      v = (i <= 15) ? i : (i <= 30) ? 30 - i : 1;
      sample(1'b1, v, 1'b0);
      turns += int'(bus8.turn);
      pds   += int'(bus8.period_done);
      nchecks++;
      if (bus8.turn !== (i == 15 || i == 30)) begin
        nerr++;
        $display("FAIL period_turn i=%0d got=%b exp=%b", i, bus8.turn, (i == 15 || i == 30));
      end
      if (i >= 2) begin
        nchecks++;
        if (bus8.locked !== 1'b1) begin
          nerr++;
          $display("FAIL period_locked i=%0d got=%b exp=1", i, bus8.locked);
        end
      end
    end
    nchecks++;
    if (turns != 2 || pds != 1 || bus8.err_cnt !== 8'd0) begin
      nerr++;
      $display("FAIL period_totals turns=%0d pd=%0d err=%0d exp 2/1/0", turns, pds, bus8.err_cnt);
    end
  endtask

  task automatic test_relock();
    do_reset();
    sample(1, 3, 0); sample(1, 4, 0); sample(1, 5, 0); sample(1, 6, 0);
    sample(1, 9, 0);
    nchecks++;
    if ({bus8.step_err, bus8.locked, bus8.dir} !== 3'b100 || bus8.err_cnt !== 8'd1) begin
      nerr++;
      $display("FAIL relock_err got serr,lock,dir=%b err=%0d exp=100 err=1",
               {bus8.step_err, bus8.locked, bus8.dir}, bus8.err_cnt);
    end
    sample(1, 10, 0);
    nchecks++;
    if ({bus8.step_err, bus8.locked, bus8.dir} !== 3'b000) begin
      nerr++;
      $display("FAIL relock_acq got=%b exp=000", {bus8.step_err, bus8.locked, bus8.dir});
    end
    sample(1, 11, 0);
    nchecks++;
    if (bus8.locked !== 1'b1 || bus8.err_cnt !== 8'd1) begin
      nerr++;
      $display("FAIL relock_lock got lock=%b err=%0d exp lock=1 err=1", bus8.locked, bus8.err_cnt);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    sample(1, 13, 0); sample(1, 14, 0); sample(1, 15, 0);
    nchecks++;
    if ({bus8.turn, bus8.dir, bus8.step_err} !== 3'b110) begin
      nerr++;
      $display("FAIL wrap_top got turn,dir,serr=%b exp=110", {bus8.turn, bus8.dir, bus8.step_err});
    end
    sample(1, 0, 0);
    nchecks++;
    if ({bus8.turn, bus8.step_err, bus8.period_done} !== 3'b010 || bus8.err_cnt !== 8'd1) begin
      nerr++;
      $display("FAIL wrap_zero got turn,serr,pd=%b err=%0d exp=010 err=1",
               {bus8.turn, bus8.step_err, bus8.period_done}, bus8.err_cnt);
    end
  endtask

  task automatic test_gap();
    do_reset();
    sample(1, 5, 0); sample(1, 6, 0); sample(1, 7, 0);
    for (int k = 0; k < 5; k++) begin
      sample(0, 0, 0);
      nchecks++;
      if ({bus8.turn, bus8.period_done, bus8.step_err, bus8.dir, bus8.locked} !== 5'b00001) begin
        nerr++;
        $display("FAIL gap_idle k=%0d got=%b exp=00001", k,
                 {bus8.turn, bus8.period_done, bus8.step_err, bus8.dir, bus8.locked});
      end
    end
    sample(1, 8, 0);
    nchecks++;
    if (bus8.step_err !== 1'b0 || bus8.locked !== 1'b1 || bus8.err_cnt !== 8'd0) begin
      nerr++;
      $display("FAIL gap_resume got serr=%b lock=%b err=%0d exp 0/1/0", bus8.step_err, bus8.locked, bus8.err_cnt);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    sample(1, 3, 0);
    for (int k = 1; k <= 6; k++) begin
      sample(1, 3, 0);
      nchecks++;
      if (bus2.err_cnt !== 2'((k > 3) ? 3 : k) || bus8.err_cnt !== 8'(k)) begin
        nerr++;
        $display("FAIL sat_count k=%0d got=%0d/%0d exp=%0d/%0d", k, bus2.err_cnt, bus8.err_cnt,
                 (k > 3) ? 3 : k, k);
      end
    end
    sample(1, 3, 1);
    nchecks++;
    if (bus2.err_cnt !== 2'd1 || bus8.err_cnt !== 8'd1) begin
      nerr++;
      $display("FAIL sat_clr_with_err got=%0d/%0d exp=1/1", bus2.err_cnt, bus8.err_cnt);
    end
    sample(1, 4, 0); sample(1, 5, 0);
    sample(0, 0, 1);
    nchecks++;
    if (bus2.err_cnt !== 2'd0 || bus8.err_cnt !== 8'd0 || bus8.locked !== 1'b1 || bus8.dir !== 1'b0) begin
      nerr++;
      $display("FAIL sat_clr_alone got err=%0d/%0d lock=%b dir=%b exp 0/0/1/0",
               bus2.err_cnt, bus8.err_cnt, bus8.locked, bus8.dir);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    sample(1, 5, 0); sample(1, 6, 0); sample(1, 7, 0); sample(1, 8, 0); sample(1, 9, 0);
    do_reset();
    nchecks++;
    if ({bus8.dir, bus8.locked} !== 2'b00) begin
      nerr++;
      $display("FAIL midreset_state got dir,lock=%b exp=00", {bus8.dir, bus8.locked});
    end
    sample(1, 8, 0);
    nchecks++;
    if (bus8.step_err !== 1'b0 || bus8.err_cnt !== 8'd0 || bus8.locked !== 1'b0) begin
      nerr++;
      $display("FAIL midreset_first got serr=%b err=%0d lock=%b exp 0/0/0", bus8.step_err, bus8.err_cnt, bus8.locked);
    end
    sample(1, 7, 0);
    nchecks++;
    if (bus8.dir !== 1'b1 || bus8.step_err !== 1'b0) begin
      nerr++;
      $display("FAIL midreset_down got dir=%b serr=%b exp 1/0", bus8.dir, bus8.step_err);
    end
    sample(1, 6, 0);
    nchecks++;
    if (bus8.locked !== 1'b1 || bus8.dir !== 1'b1) begin
      nerr++;
      $display("FAIL midreset_lock got lock=%b dir=%b exp 1/1", bus8.locked, bus8.dir);
    end
  endtask

  // Mostly-legal stream with occasional glitches, gaps and clears; scoreboard only.
  task automatic test_back_to_back();
    int cur, up, r;
    do_reset();
    cur = 4; up = 1;
    for (int i = 0; i < 200; i++) begin
      r = int'($urandom_range(0, 19));
      if (r == 0) cur = int'($urandom_range(0, MAXV));
      else if (r > 2) begin
        if (up == 1 && cur == MAXV) up = 0;
        else if (up == 0 && cur == 0) up = 1;
        cur = up ? cur + 1 : cur - 1;
      end
      sample(r != 1, cur, r == 2);
    end
  endtask

  initial begin
    bus8.s_valid = 1'b0; bus8.s = '0; bus8.clr_err = 1'b0;
    bus2.s_valid = 1'b0; bus2.s = '0; bus2.clr_err = 1'b0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_period();
    test_relock();
    test_wrap();
    test_gap();
    test_saturate();
    test_reset_mid();
    test_back_to_back();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end
endmodule
